// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: pipeline sequencer for a 5-stage datapath without forwarding.
// A 3-entry scoreboard of in-flight register writes (EX, MEM, WB) detects RAW
// hazards against the instruction in ID. On a hazard, IF/ID is frozen and a
// bubble goes into ID/EX. A MEM-stage redirect flushes the younger stages.
// Statistics counters and a consecutive-stall watchdog are kept alongside.
module hazard_stall_ctrl #(
   parameter int REG_W      = 6,
   parameter int WB_BYPASS  = 0,
   parameter int R0_IS_ZERO = 1,
   parameter int MAX_STALL  = 7,
   parameter int CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             id_valid,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic             id_uses_rs,
   input  logic             id_uses_rt,
   input  logic             id_reg_write,
   input  logic [REG_W-1:0] id_rd,
   input  logic             mem_redirect,
   output logic             pc_en,
   output logic             ifid_en,
   output logic             ifid_flush,
   output logic             idex_bubble,
   output logic             exmem_flush,
   output logic [1:0]       state,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt,
   output logic             wdog_err
);

   typedef enum logic [1:0] {
      ST_RUN   = 2'b00,
      ST_STALL = 2'b01,
      ST_FLUSH = 2'b10
   } state_t;

   // The watchdog counter only has to count one past the limit before it saturates.
   localparam int WD_W = $clog2(MAX_STALL + 2);
   localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(MAX_STALL);
   localparam logic [WD_W-1:0] WD_SAT   = WD_W'(MAX_STALL + 1);

   // Scoreboard entries: a valid flag plus the destination register.
   logic             sb_ex_v_reg,  sb_ex_v_next;
   logic [REG_W-1:0] sb_ex_rd_reg, sb_ex_rd_next;
   logic             sb_mem_v_reg, sb_mem_v_next;
   logic [REG_W-1:0] sb_mem_rd_reg, sb_mem_rd_next;
   logic             sb_wb_v_reg,  sb_wb_v_next;
   logic [REG_W-1:0] sb_wb_rd_reg, sb_wb_rd_next;

   state_t           state_reg, state_next;
   logic [CNT_W-1:0] stall_cnt_reg, stall_cnt_next;
   logic [CNT_W-1:0] flush_cnt_reg, flush_cnt_next;
   logic [WD_W-1:0]  wdog_cnt_reg, wdog_cnt_next;
   logic             wdog_err_reg, wdog_err_next;

   logic rs_match;
   logic rt_match;
   logic haz;
   logic redirect;
   logic stall_cycle;

   function automatic logic entry_hit(input logic v, input logic [REG_W-1:0] rd,
                                      input logic [REG_W-1:0] r);
      return v && (rd == r);
   endfunction

   // Register 0 is hard-wired, so reading it never depends on an older write.
   assign rs_match = !((R0_IS_ZERO != 0) && (id_rs == '0)) &&
                     (entry_hit(sb_ex_v_reg, sb_ex_rd_reg, id_rs) ||
                      entry_hit(sb_mem_v_reg, sb_mem_rd_reg, id_rs) ||
                      ((WB_BYPASS == 0) && entry_hit(sb_wb_v_reg, sb_wb_rd_reg, id_rs)));

   assign rt_match = !((R0_IS_ZERO != 0) && (id_rt == '0)) &&
                     (entry_hit(sb_ex_v_reg, sb_ex_rd_reg, id_rt) ||
                      entry_hit(sb_mem_v_reg, sb_mem_rd_reg, id_rt) ||
                      ((WB_BYPASS == 0) && entry_hit(sb_wb_v_reg, sb_wb_rd_reg, id_rt)));

   assign haz         = id_valid & ((id_uses_rs & rs_match) | (id_uses_rt & rt_match));
   assign redirect    = mem_redirect;
   assign stall_cycle = haz & ~redirect;

   // Pipeline control outputs: redirect beats hazard beats run; reset forces a safe idle.
   always_comb begin
      pc_en       = 1'b1;
      ifid_en     = 1'b1;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
      exmem_flush = 1'b0;
      if (redirect) begin
         ifid_flush  = 1'b1;
         idex_bubble = 1'b1;
         exmem_flush = 1'b1;
      end else if (haz) begin
         pc_en       = 1'b0;
         ifid_en     = 1'b0;
         idex_bubble = 1'b1;
      end
      if (!rst_n) begin
         pc_en       = 1'b0;
         ifid_en     = 1'b0;
         ifid_flush  = 1'b1;
         idex_bubble = 1'b1;
         exmem_flush = 1'b1;
      end
   end

   // Next scoreboard, state, counters and watchdog.
   always_comb begin
      sb_wb_v_next   = sb_mem_v_reg;
      sb_wb_rd_next  = sb_mem_rd_reg;
      sb_mem_v_next  = sb_ex_v_reg;
      sb_mem_rd_next = sb_ex_rd_reg;
      sb_ex_v_next   = 1'b0;
      sb_ex_rd_next  = sb_ex_rd_reg;
      state_next     = ST_RUN;
      stall_cnt_next = stall_cnt_reg;
      flush_cnt_next = flush_cnt_reg;
      wdog_cnt_next  = '0;
      wdog_err_next  = wdog_err_reg;

      if (redirect) begin
         // The instruction in EX is squashed along with the younger ones.
         sb_mem_v_next = 1'b0;
         state_next    = ST_FLUSH;
         if (flush_cnt_reg != '1)
            flush_cnt_next = flush_cnt_reg + CNT_W'(1);
      end else if (haz) begin
         state_next = ST_STALL;
         if (stall_cnt_reg != '1)
            stall_cnt_next = stall_cnt_reg + CNT_W'(1);
         wdog_cnt_next = (wdog_cnt_reg == WD_SAT) ? wdog_cnt_reg : wdog_cnt_reg + WD_W'(1);
         // The incremented count exceeds the limit exactly when the old one reached it.
         if (wdog_cnt_reg >= WD_LIMIT)
            wdog_err_next = 1'b1;
      end else begin
         sb_ex_v_next  = id_valid & id_reg_write & ~((R0_IS_ZERO != 0) && (id_rd == '0));
         sb_ex_rd_next = id_rd;
      end
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sb_ex_v_reg   <= 1'b0;
         sb_ex_rd_reg  <= '0;
         sb_mem_v_reg  <= 1'b0;
         sb_mem_rd_reg <= '0;
         sb_wb_v_reg   <= 1'b0;
         sb_wb_rd_reg  <= '0;
         state_reg     <= ST_RUN;
         stall_cnt_reg <= '0;
         flush_cnt_reg <= '0;
         wdog_cnt_reg  <= '0;
         wdog_err_reg  <= 1'b0;
      end else begin
         sb_ex_v_reg   <= sb_ex_v_next;
         sb_ex_rd_reg  <= sb_ex_rd_next;
         sb_mem_v_reg  <= sb_mem_v_next;
         sb_mem_rd_reg <= sb_mem_rd_next;
         sb_wb_v_reg   <= sb_wb_v_next;
         sb_wb_rd_reg  <= sb_wb_rd_next;
         state_reg     <= state_next;
         stall_cnt_reg <= stall_cnt_next;
         flush_cnt_reg <= flush_cnt_next;
         wdog_cnt_reg  <= wdog_cnt_next;
         wdog_err_reg  <= wdog_err_next;
      end
   end

   assign state     = state_reg;
   assign stall_cnt = stall_cnt_reg;
   assign flush_cnt = flush_cnt_reg;
   assign wdog_err  = wdog_err_reg;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: two instances share one stimulus stream.
// dut_a uses default parameters; dut_b has a write-before-read register file,
// 3-bit counters and a watchdog limit of 1 so saturation and watchdog trip are reachable.
module tb_hazard_stall_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       id_valid, id_uses_rs, id_uses_rt, id_reg_write, mem_redirect;
   logic [5:0] id_rs, id_rt, id_rd;

   logic        a_pc_en, a_ifid_en, a_ifid_flush, a_idex_bubble, a_exmem_flush, a_wdog;
   logic [1:0]  a_state;
   logic [15:0] a_stall_cnt, a_flush_cnt;
   logic        b_pc_en, b_ifid_en, b_ifid_flush, b_idex_bubble, b_exmem_flush, b_wdog;
   logic [1:0]  b_state;
   logic [2:0]  b_stall_cnt, b_flush_cnt;

   always #5 clk = ~clk;

   hazard_stall_ctrl dut_a (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_reg_write(id_reg_write),
      .id_rd(id_rd), .mem_redirect(mem_redirect), .pc_en(a_pc_en), .ifid_en(a_ifid_en),
      .ifid_flush(a_ifid_flush), .idex_bubble(a_idex_bubble), .exmem_flush(a_exmem_flush),
      .state(a_state), .stall_cnt(a_stall_cnt), .flush_cnt(a_flush_cnt), .wdog_err(a_wdog)
   );

   hazard_stall_ctrl #(.WB_BYPASS(1), .CNT_W(3), .MAX_STALL(1)) dut_b (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_reg_write(id_reg_write),
      .id_rd(id_rd), .mem_redirect(mem_redirect), .pc_en(b_pc_en), .ifid_en(b_ifid_en),
      .ifid_flush(b_ifid_flush), .idex_bubble(b_idex_bubble), .exmem_flush(b_exmem_flush),
      .state(b_state), .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt), .wdog_err(b_wdog)
   );

   int n_total = 0;
   int n_bad   = 0;
   int stalls[2];

   // Reference model state per instance: entries 0=EX, 1=MEM, 2=WB.
   bit         m_v[2][3];
   logic [5:0] m_rd[2][3];
   int         m_state[2], m_scnt[2], m_fcnt[2], m_consec[2];
   bit         m_wdog[2];
   bit         m_byp[2]    = '{1'b0, 1'b1};
   int         m_cmax[2]   = '{65535, 7};
   int         m_mstall[2] = '{7, 1};

   typedef struct {
      int         dut;
      logic [4:0] comb;
      int         st;
      int         scnt;
      int         fcnt;
      bit         wdog;
   } exp_t;

   exp_t comb_q[$];
   exp_t reg_q[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic logic [4:0] get_comb(input int k);
      if (k == 0) return {a_pc_en, a_ifid_en, a_ifid_flush, a_idex_bubble, a_exmem_flush};
      return {b_pc_en, b_ifid_en, b_ifid_flush, b_idex_bubble, b_exmem_flush};
   endfunction

   function automatic logic [31:0] get_state(input int k);
      return (k == 0) ? 32'(a_state) : 32'(b_state);
   endfunction

   function automatic logic [31:0] get_scnt(input int k);
      return (k == 0) ? 32'(a_stall_cnt) : 32'(b_stall_cnt);
   endfunction

   function automatic logic [31:0] get_fcnt(input int k);
      return (k == 0) ? 32'(a_flush_cnt) : 32'(b_flush_cnt);
   endfunction

   function automatic logic [31:0] get_wdog(input int k);
      return (k == 0) ? 32'(a_wdog) : 32'(b_wdog);
   endfunction

   function automatic bit m_match(input int k, input logic [5:0] r);
      if (r == 6'd0) return 1'b0;
      for (int j = 0; j < 3; j++) begin
         if (j == 2 && m_byp[k]) continue;
         if (m_v[k][j] && m_rd[k][j] == r) return 1'b1;
      end
      return 1'b0;
   endfunction

   task automatic m_reset();
      for (int k = 0; k < 2; k++) begin
         for (int j = 0; j < 3; j++) begin
            m_v[k][j]  = 1'b0;
            m_rd[k][j] = '0;
         end
         m_state[k] = 0; m_scnt[k] = 0; m_fcnt[k] = 0; m_consec[k] = 0; m_wdog[k] = 1'b0;
      end
   endtask

   task automatic set_id(input bit v, input int rs, input int rt, input bit urs,
                         input bit urt, input bit wr, input int rd);
      id_valid = v; id_rs = 6'(rs); id_rt = 6'(rt);
      id_uses_rs = urs; id_uses_rt = urt; id_reg_write = wr; id_rd = 6'(rd);
   endtask

   // One clock cycle: predict, push, then pop and compare as the DUT responds.
   task automatic step();
      exp_t e;
      bit   haz;
      for (int k = 0; k < 2; k++) begin
         haz = id_valid && ((id_uses_rs && m_match(k, id_rs)) ||
                            (id_uses_rt && m_match(k, id_rt)));
         e.dut = k;
         if (mem_redirect)  e.comb = 5'b11111;
         else if (haz)      e.comb = 5'b00010;
         else               e.comb = 5'b11000;
         comb_q.push_back(e);
         m_v[k][2] = m_v[k][1]; m_rd[k][2] = m_rd[k][1];
         if (mem_redirect) begin
            m_v[k][1] = 1'b0; m_v[k][0] = 1'b0;
            m_state[k] = 2;
            if (m_fcnt[k] < m_cmax[k]) m_fcnt[k]++;
            m_consec[k] = 0;
         end else if (haz) begin
            m_v[k][1] = m_v[k][0]; m_rd[k][1] = m_rd[k][0]; m_v[k][0] = 1'b0;
            m_state[k] = 1;
            if (m_scnt[k] < m_cmax[k]) m_scnt[k]++;
            m_consec[k]++;
            if (m_consec[k] > m_mstall[k]) m_wdog[k] = 1'b1;
         end else begin
            m_v[k][1] = m_v[k][0]; m_rd[k][1] = m_rd[k][0];
            m_v[k][0] = id_valid && id_reg_write && (id_rd != 6'd0);
            m_rd[k][0] = id_rd;
            m_state[k] = 0;
            m_consec[k] = 0;
         end
         e.st = m_state[k]; e.scnt = m_scnt[k]; e.fcnt = m_fcnt[k]; e.wdog = m_wdog[k];
         reg_q.push_back(e);
      end
      #1;
      while (comb_q.size() > 0) begin
         logic [4:0] got;
         e = comb_q.pop_front();
         got = get_comb(e.dut);
         check($sformatf("ctrl[%0d]", e.dut), 32'(got), 32'(e.comb));
         if (got[4] == 1'b0) stalls[e.dut]++;
      end
      @(posedge clk);
      #1;
      while (reg_q.size() > 0) begin
         e = reg_q.pop_front();
         check($sformatf("state[%0d]", e.dut), get_state(e.dut), 32'(e.st));
         check($sformatf("stall_cnt[%0d]", e.dut), get_scnt(e.dut), 32'(e.scnt));
         check($sformatf("flush_cnt[%0d]", e.dut), get_fcnt(e.dut), 32'(e.fcnt));
         check($sformatf("wdog[%0d]", e.dut), get_wdog(e.dut), 32'(e.wdog));
      end
      @(negedge clk);
   endtask

   task automatic check_reset_vals(input string tag);
      for (int k = 0; k < 2; k++) begin
         check($sformatf("%s_ctrl[%0d]", tag, k), 32'(get_comb(k)), 32'(5'b00111));
         check($sformatf("%s_state[%0d]", tag, k), get_state(k), 32'd0);
         check($sformatf("%s_scnt[%0d]", tag, k), get_scnt(k), 32'd0);
         check($sformatf("%s_fcnt[%0d]", tag, k), get_fcnt(k), 32'd0);
         check($sformatf("%s_wdog[%0d]", tag, k), get_wdog(k), 32'd0);
      end
   endtask

   task automatic add_r5();  set_id(1, 2, 3, 1, 1, 1, 5); endtask
   task automatic sub_r7();  set_id(1, 5, 1, 1, 1, 1, 7); endtask
   task automatic nop();     set_id(0, 0, 0, 0, 0, 0, 0); endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation ran past its time limit");
      $fatal(1, "timeout");
   end

   initial begin
      m_reset();
      nop();
      mem_redirect = 1'b0;
      rst_n = 1'b0;
      #3;
      check_reset_vals("por");
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Back-to-back RAW dependency.
      stalls = '{0, 0};
      add_r5(); step();
      sub_r7(); repeat (5) step();
      nop(); step();
      check("t1_stalls_a", 32'(stalls[0]), 32'd3);
      check("t1_stalls_b", 32'(stalls[1]), 32'd2);
      check("t1_scnt_a", 32'(a_stall_cnt), 32'd3);

      // Dependency at distance 3.
      stalls = '{0, 0};
      add_r5(); step();
      nop(); step(); step();
      sub_r7(); repeat (3) step();
      nop(); step();
      check("t2_stalls_a", 32'(stalls[0]), 32'd1);
      check("t2_stalls_b", 32'(stalls[1]), 32'd0);

      // Register 0 never creates a hazard.
      stalls = '{0, 0};
      set_id(1, 2, 3, 1, 1, 1, 0); step();
      set_id(1, 0, 0, 1, 1, 1, 8); step();
      nop(); step();
      check("t3_stalls_a", 32'(stalls[0]), 32'd0);
      check("t3_stalls_b", 32'(stalls[1]), 32'd0);
      check("t3_scnt_a", 32'(a_stall_cnt), 32'd4);

      // Redirect in the second stall cycle.
      stalls = '{0, 0};
      add_r5(); step();
      sub_r7(); step();
      mem_redirect = 1'b1;
      #1;
      check("t4_pc_en", 32'(a_pc_en), 32'd1);
      check("t4_flushes", 32'({a_ifid_flush, a_idex_bubble, a_exmem_flush}), 32'd7);
      step();
      check("t4_state", 32'(a_state), 32'd2);
      check("t4_fcnt", 32'(a_flush_cnt), 32'd1);
      mem_redirect = 1'b0;
      nop(); repeat (3) step();
      check("t4_stalls_a", 32'(stalls[0]), 32'd1);
      check("t4_stalls_b", 32'(stalls[1]), 32'd1);

      // Asynchronous reset in the middle of a stall.
      add_r5(); step();
      sub_r7(); step();
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_vals("t5");
      m_reset();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      nop(); step();
      check("t5_pc_en_after", 32'(a_pc_en), 32'd1);

      // Counter saturation and watchdog trip on dut_b.
      add_r5(); step();
      sub_r7(); step();
      check("t6_wdog_pre", 32'(b_wdog), 32'd0);
      step();
      check("t6_wdog_set", 32'(b_wdog), 32'd1);
      step(); step();
      repeat (3) begin
         add_r5(); step();
         sub_r7(); repeat (4) step();
      end
      nop(); step();
      check("t6_scnt_b_sat", 32'(b_stall_cnt), 32'd7);
      check("t6_wdog_b", 32'(b_wdog), 32'd1);
      check("t6_wdog_a", 32'(a_wdog), 32'd0);
      check("t6_scnt_a", 32'(a_stall_cnt), 32'd12);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
